// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, opcode field bounds and the opcodes
// that the fetch unit and the control decoder both refer to.
package mips_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, decode handshake and
// branch redirect from execute. master = fetch unit, slave = memory/pipeline side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [5:0]        op_code;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, op_code, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, op_code, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem request, one held
// instruction for decode. Define IFU_PERF_CNT_EN to add fetch/kill/stall counters.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        kill_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

  logic              req_valid;
  logic              instr_valid;
  logic              req_hs;
  logic [ADDR_W-1:0] redirect_aligned;

  assign req_hs           = req_valid & bus.imem_req_ready;
  assign redirect_aligned = bus.redirect_pc & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    unique case (state_q)
      REQ: begin
        if (req_hs) begin
          state_d    = WAIT;
          instr_pc_d = pc_q;
        end
        // A request accepted alongside a redirect fetched the old pc: kill it.
        if (bus.redirect) begin
          pc_d   = redirect_aligned;
          kill_d = req_hs;
        end
      end
      WAIT: begin
        if (bus.redirect) pc_d = redirect_aligned;
        if (bus.imem_rsp_valid) begin
          if (kill_q || bus.redirect) begin
            state_d = REQ;
            kill_d  = 1'b0;
          end else begin
            instr_d = bus.imem_rsp_data;
            pc_d    = pc_q + ADDR_W'(4);
            state_d = ISSUE;
          end
        end else if (bus.redirect) begin
          kill_d = 1'b1;
        end
      end
      ISSUE: begin
        if (bus.redirect) begin
          pc_d    = redirect_aligned;
          state_d = REQ;
        end else if (bus.instr_ready) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_comb begin
    req_valid   = (state_q == REQ) && !rst;
    instr_valid = (state_q == ISSUE);
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.instr_valid    = instr_valid;
  assign bus.instr          = instr_q;
  assign bus.op_code        = instr_q[OPC_MSB:OPC_LSB];
  assign bus.instr_pc       = instr_pc_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] kill_cnt_q, kill_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        discard_rsp;
  logic        drop_instr;

  assign discard_rsp = (state_q == WAIT) & bus.imem_rsp_valid & (kill_q | bus.redirect);
  assign drop_instr  = instr_valid & bus.redirect & ~bus.instr_ready;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(instr_valid & bus.instr_ready);
    kill_cnt_d  = kill_cnt_q + 32'(discard_rsp | drop_instr);
    stall_cnt_d = stall_cnt_q + 32'(instr_valid & ~bus.instr_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign kill_cnt  = kill_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // Memory must only answer the single outstanding request.
  rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> (state_q == WAIT));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a main instance (RESET_PC=0) and a
// second instance (RESET_PC=FFFF_FFFC) for the PC wrap case.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_w;
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  instr_fetch_unit_if #(.ADDR_W(32)) bus ();
  instr_fetch_unit_if #(.ADDR_W(32)) bus_w ();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt, kill_cnt, stall_cnt;
  logic [31:0] fetch_cnt_w, kill_cnt_w, stall_cnt_w;
`endif

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .kill_cnt(kill_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk),
    .rst(rst_w),
    .bus(bus_w)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt_w),
    .kill_cnt(kill_cnt_w),
    .stall_cnt(stall_cnt_w)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request and accept it on the next edge.
  task automatic accept_req(output logic [31:0] addr, output bit ok);
    ok   = 1'b0;
    addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.imem_req_valid === 1'b1) begin
        ok   = 1'b1;
        addr = bus.imem_addr;
        bus.imem_req_ready = 1'b1;
      end
      tick();
    end
    bus.imem_req_ready = 1'b0;
    $display("req  addr=%h accepted=%0d", addr, ok);
  endtask

  task automatic send_rsp(input logic [31:0] data, input logic [31:0] pc, input bit used);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    if (used) sb_q.push_back('{word: data, pc: pc});
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    $display("rsp  data=%h used=%0d", data, used);
  endtask

  // Wait for instr_valid, hold decode off for `stall` cycles, then consume.
  task automatic take_instr(input int stall);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.instr_valid === 1'b1) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok || sb_q.size() == 0) begin
      $display("FAIL take_instr_avail valid_seen=%0d sb_size=%0d required=1/>0", ok, sb_q.size());
      return;
    end
    passed++;
    e = sb_q[0];
    for (int s = 0; s <= stall; s++) begin
      checks++;
      if ({bus.instr, bus.op_code, bus.instr_pc} !== {e.word, e.word[31:26], e.pc})
        $display("FAIL instr_hold cyc=%0d got word=%h op=%h pc=%h exp word=%h op=%h pc=%h",
                 s, bus.instr, bus.op_code, bus.instr_pc, e.word, e.word[31:26], e.pc);
      else passed++;
      if (s < stall) begin
        checks++;
        if ({bus.instr_valid, bus.imem_req_valid} !== 2'b10)
          $display("FAIL stall_hold cyc=%0d got valid=%b req=%b exp valid=1 req=0",
                   s, bus.instr_valid, bus.imem_req_valid);
        else passed++;
        tick();
      end
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    void'(sb_q.pop_front());
    $display("take pc=%h word=%h stall=%0d", e.pc, e.word, stall);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.imem_req_valid, bus.instr_valid} !== 2'b00)
      $display("FAIL reset_valids got req=%b instr=%b exp 0 0", bus.imem_req_valid, bus.instr_valid);
    else passed++;
    checks++;
    if ({bus.instr, bus.op_code, bus.instr_pc} !== {32'h0, 6'h0, 32'h0})
      $display("FAIL reset_regs got instr=%h op=%h pc=%h exp 0 0 0", bus.instr, bus.op_code, bus.instr_pc);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req_valid, bus.imem_addr} !== {1'b1, 32'h0})
      $display("FAIL reset_first_req got req=%b addr=%h exp 1 00000000", bus.imem_req_valid, bus.imem_addr);
    else passed++;
  endtask

  task automatic test_basic();
    logic [31:0] a;
    bit          ok;
    accept_req(a, ok);
    checks++;
    if (!ok || a !== 32'h0) $display("FAIL basic_addr got=%h ok=%0d exp=00000000", a, ok);
    else passed++;
    checks++;
    if (bus.instr_valid !== 1'b0) $display("FAIL basic_early_valid got=%b exp=0", bus.instr_valid);
    else passed++;
    send_rsp(32'h8C22_0004, 32'h0, 1'b1);
    checks++;
    if ({bus.instr_valid, bus.op_code, bus.instr_pc} !== {1'b1, OP_LW, 32'h0})
      $display("FAIL basic_issue got valid=%b op=%h pc=%h exp 1 23 00000000",
               bus.instr_valid, bus.op_code, bus.instr_pc);
    else passed++;
  endtask

  task automatic test_backpressure();
    take_instr(5);
    checks++;
    if ({bus.imem_req_valid, bus.imem_addr} !== {1'b1, 32'h4})
      $display("FAIL bp_next_req got req=%b addr=%h exp 1 00000004", bus.imem_req_valid, bus.imem_addr);
    else passed++;
`ifdef IFU_PERF_CNT_EN
    checks++;
    if ({fetch_cnt, stall_cnt} !== {32'd1, 32'd5})
      $display("FAIL bp_counters got fetch=%0d stall=%0d exp 1 5", fetch_cnt, stall_cnt);
    else passed++;
`endif
  endtask

  task automatic test_redirect_wait();
    logic [31:0] a;
    bit          ok;
    accept_req(a, ok);
    checks++;
    if (!ok || a !== 32'h4) $display("FAIL rw_addr got=%h ok=%0d exp=00000004", a, ok);
    else passed++;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    send_rsp(32'h1000_0003, 32'h4, 1'b0);
    checks++;
    if ({bus.instr_valid, bus.imem_req_valid, bus.imem_addr} !== {1'b0, 1'b1, 32'h40})
      $display("FAIL rw_after got valid=%b req=%b addr=%h exp 0 1 00000040",
               bus.instr_valid, bus.imem_req_valid, bus.imem_addr);
    else passed++;
`ifdef IFU_PERF_CNT_EN
    checks++;
    if (kill_cnt !== 32'd1) $display("FAIL rw_kill_cnt got=%0d exp=1", kill_cnt);
    else passed++;
`endif
  endtask

  task automatic test_redirect_same_cycle();
    logic [31:0] a;
    bit          ok;
    accept_req(a, ok);
    send_rsp(32'h1000_0005, 32'h40, 1'b1);
    take_instr(0);
    accept_req(a, ok);
    checks++;
    if (!ok || a !== 32'h44) $display("FAIL rs_addr got=%h ok=%0d exp=00000044", a, ok);
    else passed++;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h43;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data = 32'hAC22_0008;
    tick();
    bus.redirect = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    checks++;
    if ({bus.instr_valid, bus.imem_req_valid, bus.imem_addr} !== {1'b0, 1'b1, 32'h40})
      $display("FAIL rs_after got valid=%b req=%b addr=%h exp 0 1 00000040",
               bus.instr_valid, bus.imem_req_valid, bus.imem_addr);
    else passed++;
`ifdef IFU_PERF_CNT_EN
    checks++;
    if (kill_cnt !== 32'd2) $display("FAIL rs_kill_cnt got=%0d exp=2", kill_cnt);
    else passed++;
`endif
  endtask

  task automatic test_redirect_req();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h80;
    tick();
    bus.redirect = 1'b0;
    repeat (2) begin
      checks++;
      if ({bus.imem_req_valid, bus.imem_addr} !== {1'b1, 32'h80})
        $display("FAIL rq_addr got req=%b addr=%h exp 1 00000080", bus.imem_req_valid, bus.imem_addr);
      else passed++;
      tick();
    end
  endtask

  task automatic test_redirect_issue();
    logic [31:0] a;
    bit          ok;
    exp_t        e;
    accept_req(a, ok);
    send_rsp(32'hAC22_0008, 32'h80, 1'b1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    void'(sb_q.pop_front());
    checks++;
    if ({bus.instr_valid, bus.imem_req_valid, bus.imem_addr} !== {1'b0, 1'b1, 32'h100})
      $display("FAIL ri_drop got valid=%b req=%b addr=%h exp 0 1 00000100",
               bus.instr_valid, bus.imem_req_valid, bus.imem_addr);
    else passed++;
    accept_req(a, ok);
    send_rsp(32'h0000_0820, 32'h100, 1'b1);
    e = sb_q.pop_front();
    checks++;
    if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, e.word, e.pc})
      $display("FAIL ri_consume got valid=%b word=%h pc=%h exp 1 %h %h",
               bus.instr_valid, bus.instr, bus.instr_pc, e.word, e.pc);
    else passed++;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    bus.instr_ready = 1'b1;
    tick();
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b0;
    checks++;
    if ({bus.instr_valid, bus.imem_addr} !== {1'b0, 32'h200})
      $display("FAIL ri_next got valid=%b addr=%h exp 0 00000200", bus.instr_valid, bus.imem_addr);
    else passed++;
`ifdef IFU_PERF_CNT_EN
    checks++;
    if ({fetch_cnt, kill_cnt} !== {32'd3, 32'd3})
      $display("FAIL ri_counters got fetch=%0d kill=%0d exp 3 3", fetch_cnt, kill_cnt);
    else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    bit          ok;
    int          last_cyc;
    last_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      accept_req(a, ok);
      checks++;
      if (!ok || a !== 32'h200 + 32'(4 * k))
        $display("FAIL b2b_addr k=%0d got=%h exp=%h", k, a, 32'h200 + 32'(4 * k));
      else passed++;
      if (k > 0) begin
        checks++;
        if (cyc - last_cyc != 3) $display("FAIL b2b_period got=%0d exp=3", cyc - last_cyc);
        else passed++;
      end
      last_cyc = cyc;
      send_rsp(32'h0000_0020 | 32'(k << 11), a, 1'b1);
      take_instr(0);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] a;
    bit          ok;
    accept_req(a, ok);
    send_rsp(32'h8C23_0010, a, 1'b1);
    rst = 1'b1;
    tick();
    sb_q.delete();
    checks++;
    if ({bus.instr_valid, bus.imem_req_valid} !== 2'b00)
      $display("FAIL mr_drop got valid=%b req=%b exp 0 0", bus.instr_valid, bus.imem_req_valid);
    else passed++;
    rst = 1'b0;
    accept_req(a, ok);
    checks++;
    if (!ok || a !== 32'h0) $display("FAIL mr_addr got=%h ok=%0d exp=00000000", a, ok);
    else passed++;
  endtask

  task automatic test_pc_wrap();
    bit ok;
    rst_w = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus_w.imem_req_valid === 1'b1) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok || bus_w.imem_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_first got req=%b addr=%h exp 1 fffffffc", ok, bus_w.imem_addr);
    else passed++;
    bus_w.imem_req_ready = 1'b1;
    tick();
    bus_w.imem_req_ready = 1'b0;
    bus_w.imem_rsp_valid = 1'b1;
    bus_w.imem_rsp_data  = 32'h1000_0001;
    tick();
    bus_w.imem_rsp_valid = 1'b0;
    checks++;
    if ({bus_w.instr_valid, bus_w.op_code, bus_w.instr_pc} !== {1'b1, OP_BEQ, 32'hFFFF_FFFC})
      $display("FAIL wrap_issue got valid=%b op=%h pc=%h exp 1 04 fffffffc",
               bus_w.instr_valid, bus_w.op_code, bus_w.instr_pc);
    else passed++;
    bus_w.instr_ready = 1'b1;
    tick();
    bus_w.instr_ready = 1'b0;
    checks++;
    if ({bus_w.imem_req_valid, bus_w.imem_addr} !== {1'b1, 32'h0})
      $display("FAIL wrap_next got req=%b addr=%h exp 1 00000000", bus_w.imem_req_valid, bus_w.imem_addr);
    else passed++;
    $display("wrap pc=fffffffc next=%h", bus_w.imem_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rst_w = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus_w.imem_req_ready = 1'b0;
    bus_w.imem_rsp_valid = 1'b0;
    bus_w.imem_rsp_data = '0;
    bus_w.instr_ready = 1'b0;
    bus_w.redirect = 1'b0;
    bus_w.redirect_pc = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_redirect_req();
    test_redirect_issue();
    test_back_to_back();
    test_mid_reset();
    test_pc_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
